cart_bus_capture: RTL and testbench

- FPGA-side receiver for the N64 cartridge AD bus. Directly consumes cart_ad, cart_rd, cart_alel and cart_aleh as driven by the N64 (or by the cartridge waveform stimulus in simulation).
- Synchronises the asynchronous bus and decodes the ALEH/ALEL address phases. On every RD rising edge it captures one 16-bit data half-word.
- Pushes {address, half-word} beats into an internal FIFO with a valid/ready output toward the capture/logging logic.
- Requires clk of at least 50 MHz, so every 100 ns bus phase is seen in at least 5 samples.

---
 rtl/cart_bus_pkg.sv | 20 ++
 rtl/cart_capture_fifo.sv | 47 ++++
 rtl/cart_bus_capture.sv | 170 +++++++++++++++++
 tb/tb_cart_bus_capture.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cart_bus_pkg.sv
// Shared types for the N64 cartridge AD-bus capture block.
package cart_bus_pkg;

    localparam int CART_ADDR_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ALEL,
        HI_PHASE,
        LO_PHASE,
        DATA
    } cart_cap_state_t;

    typedef struct packed {
        logic [CART_ADDR_W-1:0] addr;
        logic [15:0]            data;
        logic                   first;
    } cart_beat_t;

endpackage

// File: rtl/cart_capture_fifo.sv
// Show-ahead synchronous FIFO of captured cartridge beats.
module cart_capture_fifo
    import cart_bus_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push_i,
    input  cart_beat_t push_data_i,
    input  logic       pop_i,
    output cart_beat_t pop_data_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    cart_beat_t  mem_q [FIFO_DEPTH];
    logic [AW:0] wptr_q;
    logic [AW:0] rptr_q;
    logic        do_push;
    logic        do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign do_push = push_i && (!full_o || do_pop);

    assign pop_data_o = empty_o ? cart_beat_t'('0) : mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/cart_bus_capture.sv
// N64 cartridge AD-bus receiver: synchronises strobes, decodes ALEH/ALEL
// address phases and queues {address, half-word} beats on each RD rise.
module cart_bus_capture
    import cart_bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 16,
    parameter int ADDR_INC    = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [15:0]            cart_ad_i,
    input  logic                   cart_rd_i,
    input  logic                   cart_alel_i,
    input  logic                   cart_aleh_i,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [CART_ADDR_W-1:0] m_addr,
    output logic [15:0]            m_data,
    output logic                   m_first,
    output logic                   overflow,
    input  logic                   clr_overflow,
    output logic                   proto_err,
    output logic                   busy
);

    // Strobe bundle order: {aleh, alel, rd}
    logic [2:0]  sync_q [SYNC_STAGES];
    logic [2:0]  hist_q;
    logic [2:0]  strb;
    logic [15:0] ad_pipe_q [SYNC_STAGES+1];

    logic        rd_rise_q, alel_rise_q, alel_fall_q, aleh_rise_q, aleh_fall_q;
    logic        alel_q, aleh_q;
    logic [15:0] ad_q;

    cart_cap_state_t        state_q;
    logic [CART_ADDR_W-1:0] addr_q;
    logic                   first_q;
    logic                   push_q;
    cart_beat_t             beat_q;
    logic                   perr_q;
    logic                   ovf_q;

    cart_beat_t head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;

    assign strb = sync_q[SYNC_STAGES-1];

    // Edge pulses are registered together with the AD sample taken at the
    // strobe's previous level, keeping the two aligned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            for (int unsigned i = 0; i <= SYNC_STAGES; i++) ad_pipe_q[i] <= '0;
            hist_q      <= '0;
            rd_rise_q   <= 1'b0;
            alel_rise_q <= 1'b0;
            alel_fall_q <= 1'b0;
            aleh_rise_q <= 1'b0;
            aleh_fall_q <= 1'b0;
            alel_q      <= 1'b0;
            aleh_q      <= 1'b0;
            ad_q        <= '0;
        end else begin
            sync_q[0] <= {cart_aleh_i, cart_alel_i, cart_rd_i};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            hist_q       <= strb;
            ad_pipe_q[0] <= cart_ad_i;
            for (int unsigned i = 1; i <= SYNC_STAGES; i++) ad_pipe_q[i] <= ad_pipe_q[i-1];
            rd_rise_q   <= strb[0] & ~hist_q[0];
            alel_rise_q <= strb[1] & ~hist_q[1];
            alel_fall_q <= ~strb[1] & hist_q[1];
            aleh_rise_q <= strb[2] & ~hist_q[2];
            aleh_fall_q <= ~strb[2] & hist_q[2];
            alel_q      <= strb[1];
            aleh_q      <= strb[2];
            ad_q        <= ad_pipe_q[SYNC_STAGES];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            first_q <= 1'b0;
            push_q  <= 1'b0;
            beat_q  <= '0;
            perr_q  <= 1'b0;
        end else begin
            push_q <= 1'b0;
            perr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (aleh_rise_q) state_q <= WAIT_ALEL;
                    if (alel_rise_q || alel_fall_q) perr_q <= 1'b1;
                end
                WAIT_ALEL: begin
                    if (alel_rise_q && aleh_q) state_q <= HI_PHASE;
                    else if (aleh_fall_q && !alel_q) state_q <= IDLE;
                end
                HI_PHASE: begin
                    if (aleh_fall_q && alel_fall_q) begin
                        perr_q  <= 1'b1;
                        state_q <= IDLE;
                    end else if (aleh_fall_q && alel_q) begin
                        addr_q[CART_ADDR_W-1:16] <= ad_q;
                        state_q <= LO_PHASE;
                    end
                end
                LO_PHASE: begin
                    if (alel_fall_q) begin
                        addr_q[15:0] <= ad_q;
                        first_q      <= 1'b1;
                        state_q      <= DATA;
                    end
                end
                DATA: begin
                    if (rd_rise_q) begin
                        push_q       <= 1'b1;
                        beat_q.addr  <= addr_q;
                        beat_q.data  <= ad_q;
                        beat_q.first <= first_q;
                        addr_q       <= addr_q + CART_ADDR_W'(ADDR_INC);
                        first_q      <= 1'b0;
                    end
                    if (aleh_rise_q) state_q <= WAIT_ALEL;
                    if (alel_rise_q || alel_fall_q) perr_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pop = m_valid && m_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (push_q && fifo_full && !pop) begin
            ovf_q <= 1'b1;
        end else if (clr_overflow) begin
            ovf_q <= 1'b0;
        end
    end

    cart_capture_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (push_q),
        .push_data_i (beat_q),
        .pop_i       (pop),
        .pop_data_o  (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign m_valid   = !fifo_empty;
    assign m_addr    = head.addr;
    assign m_data    = head.data;
    assign m_first   = head.first;
    assign overflow  = ovf_q;
    assign proto_err = perr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cart_bus_capture.sv
// Directed bench for cart_bus_capture: drives cartridge bus phases and checks
// the queued beats against hand-computed values.
module tb_cart_bus_capture;

    localparam int SYNC = 2;
    localparam int DEPTH = 16;
    localparam int INC = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] cart_ad = '0;
    logic        cart_rd = 1'b1;
    logic        cart_alel = 1'b0;
    logic        cart_aleh = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_addr;
    logic [15:0] m_data;
    logic        m_first;
    logic        overflow;
    logic        clr_overflow = 1'b0;
    logic        proto_err;
    logic        busy;

    int vec_cnt = 0;
    int err_cnt = 0;
    int perr_cnt = 0;

    always #5 clk = ~clk;

    cart_bus_capture #(
        .SYNC_STAGES (SYNC),
        .FIFO_DEPTH  (DEPTH),
        .ADDR_INC    (INC)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cart_ad_i    (cart_ad),
        .cart_rd_i    (cart_rd),
        .cart_alel_i  (cart_alel),
        .cart_aleh_i  (cart_aleh),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_addr       (m_addr),
        .m_data       (m_data),
        .m_first      (m_first),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .proto_err    (proto_err),
        .busy         (busy)
    );

    always @(negedge clk) if (proto_err) perr_cnt++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_addr(input logic [31:0] a);
        cart_aleh = 1'b1; cart_ad = a[31:16]; cyc(6);
        cart_alel = 1'b1; cyc(6);
        cart_aleh = 1'b0; cyc(6);
        cart_ad = a[15:0]; cyc(6);
        cart_alel = 1'b0; cyc(6);
    endtask

    task automatic bus_rd(input logic [15:0] d);
        cart_rd = 1'b0; cart_ad = d; cyc(6);
        cart_rd = 1'b1; cyc(6);
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] d);
        bus_addr(a);
        bus_rd(d[15:0]);
        bus_rd(d[31:16]);
    endtask

    task automatic pop_check(input string tag, input logic [31:0] ea, input logic [15:0] ed, input logic ef);
        int t = 0;
        while (!m_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk({tag, ".valid"}, m_valid, 1'b1);
        chk({tag, ".addr"}, m_addr, ea);
        chk({tag, ".data"}, m_data, ed);
        chk({tag, ".first"}, m_first, ef);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".valid"}, m_valid, 1'b0);
        chk({tag, ".addr"}, m_addr, 32'h0);
        chk({tag, ".data"}, m_data, 16'h0);
        chk({tag, ".first"}, m_first, 1'b0);
        chk({tag, ".ovf"}, overflow, 1'b0);
        chk({tag, ".perr"}, proto_err, 1'b0);
        chk({tag, ".busy"}, busy, 1'b0);
    endtask

    initial begin
        cyc(3);
        check_reset_outputs("rst");
        reset_n = 1'b1;
        cyc(6);
        chk("rst.rd_idle", m_valid, 1'b0);

        // Single read with latency measurement on the first RD rise
        bus_addr(32'h1000_0040);
        chk("single.busy", busy, 1'b1);
        cart_rd = 1'b0; cart_ad = 16'hBEEF; cyc(6);
        cart_rd = 1'b1;
        repeat (SYNC + 2) @(posedge clk);
        #1 chk("lat.early", m_valid, 1'b0);
        @(posedge clk);
        #1 chk("lat.rise", m_valid, 1'b1);
        cyc(6);
        bus_rd(16'hDEAD);
        pop_check("single0", 32'h1000_0040, 16'hBEEF, 1'b1);
        pop_check("single1", 32'h1000_0042, 16'hDEAD, 1'b0);
        chk("single.empty", m_valid, 1'b0);
        chk("single.perr", perr_cnt, 0);

        // Back-to-back reads
        bus_read(32'h1000_0040, 32'h1122_3344);
        bus_read(32'h1000_1000, 32'hAABB_CCDD);
        pop_check("b2b0", 32'h1000_0040, 16'h3344, 1'b1);
        pop_check("b2b1", 32'h1000_0042, 16'h1122, 1'b0);
        pop_check("b2b2", 32'h1000_1000, 16'hCCDD, 1'b1);
        pop_check("b2b3", 32'h1000_1002, 16'hAABB, 1'b0);
        chk("b2b.empty", m_valid, 1'b0);
        chk("b2b.ovf", overflow, 1'b0);

        // Backpressure: 20 half-words into a 16-deep FIFO
        bus_addr(32'h1000_0000);
        for (int i = 0; i < 20; i++) begin
            bus_rd(16'h0100 + 16'(i));
            if (i == 15) chk("bp.ovf_before", overflow, 1'b0);
        end
        chk("bp.ovf", overflow, 1'b1);
        for (int i = 0; i < 16; i++)
            pop_check($sformatf("bp%0d", i), 32'h1000_0000 + 32'(2 * i), 16'h0100 + 16'(i), i == 0);
        chk("bp.empty", m_valid, 1'b0);
        chk("bp.ovf_sticky", overflow, 1'b1);
        clr_overflow = 1'b1; cyc(1); clr_overflow = 1'b0; cyc(1);
        chk("bp.ovf_clr", overflow, 1'b0);

        // Address wrap
        bus_addr(32'hFFFF_FFFE);
        bus_rd(16'h1111);
        bus_rd(16'h2222);
        pop_check("wrap0", 32'hFFFF_FFFE, 16'h1111, 1'b1);
        pop_check("wrap1", 32'h0000_0000, 16'h2222, 1'b0);
        chk("wrap.perr", perr_cnt, 0);

        // Both ALE strobes drop together during HI_PHASE
        cart_aleh = 1'b1; cart_ad = 16'h1234; cyc(6);
        cart_alel = 1'b1; cyc(6);
        chk("ill.busy_hi", busy, 1'b1);
        cart_aleh = 1'b0; cart_alel = 1'b0; cyc(6);
        chk("ill.perr", perr_cnt, 1);
        chk("ill.idle", busy, 1'b0);

        // RD toggles and stray ALEL in IDLE
        bus_rd(16'h5A5A);
        bus_rd(16'hA5A5);
        cyc(6);
        chk("stray.rd_nobeat", m_valid, 1'b0);
        cart_alel = 1'b1; cyc(6);
        cart_alel = 1'b0; cyc(6);
        chk("stray.alel_perr", perr_cnt, 3);
        chk("stray.idle", busy, 1'b0);

        // Reset in the middle of a burst
        bus_addr(32'h1000_0100);
        bus_rd(16'h5555);
        chk("mid.pushed", m_valid, 1'b1);
        cart_rd = 1'b0; cart_ad = 16'h6666; cyc(3);
        reset_n = 1'b0;
        #1 check_reset_outputs("mid.rst");
        cyc(3);
        cart_rd = 1'b1; cyc(1);
        reset_n = 1'b1; cyc(6);
        chk("mid.after", m_valid, 1'b0);
        bus_read(32'h1000_0080, 32'h9999_7777);
        pop_check("fresh0", 32'h1000_0080, 16'h7777, 1'b1);
        pop_check("fresh1", 32'h1000_0082, 16'h9999, 1'b0);
        chk("fresh.empty", m_valid, 1'b0);
        chk("final.perr", perr_cnt, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
